cam_capture_ctrl: RTL and testbench
===================================

// Module: cam_capture_ctrl
// PURPOSE
//  Sequences one-shot frame capture from the OV7670-style camera port: arms on a
//  capture request, waits for a clean frame start, pairs bytes into 16-bit RGB565
//  pixels and issues addressed writes to the frame buffer/FIFO. Sits between camera
//  pins (href/vsync/data) and the pixel store; replaces ad-hoc wr toggling.
// PARAMETERS
//  H_PIX    640  pixels per line (2 bytes each)
//  V_LINES  480  lines per frame
//  ADDR_W   19   pixel address width; must satisfy 2**ADDR_W >= H_PIX*V_LINES
// PORTS
//  clk           in   1       pixel clock (camera Pclk); sole clock
//  rst           in   1       asynchronous, active-high reset
//  capture_req   in   1       start request (already debounced, one-cycle or level)
//  href          in   1       line valid from camera
//  vsync         in   1       frame sync from camera (high = blanking)
//  data          in   8       camera byte bus
//  buf_full      in   1       downstream store cannot accept a write
//  pix_data      out  16      {first byte, second byte}
//  pix_addr      out  ADDR_W  linear pixel address, row*H_PIX+col
//  pix_we        out  1       one-cycle write strobe
//  busy          out  1       high in ARM/CAPTURE
//  frame_done    out  1       one-cycle pulse at end of captured frame
//  err_overflow  out  1       sticky: write dropped due to buf_full
//  err_geom      out  1       sticky: line/frame size mismatch or odd byte count
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0. Reset mid-frame aborts, no pulse.
//  - href/vsync/data registered once at input; all decisions use registered copies.
//  - FSM: IDLE -capture_req-> ARM (errors cleared, counters cleared);
//    ARM: wait vsync=1 then vsync 1->0 (frame start) -> CAPTURE;
//    CAPTURE: vsync 0->1 (frame end) -> DONE; DONE: frame_done=1 one cycle -> IDLE.
//  - capture_req ignored outside IDLE. busy=1 in ARM, CAPTURE.
//  - CAPTURE, href=1: byte phase toggles; phase0 latches high byte, phase1 forms
//    pixel. pix_we high the cycle after the registered second byte (2 clk after pin).
//  - pix_addr = current pixel index; increments after each pixel slot, written or not.
//  - buf_full=1 at write slot: pix_we suppressed, err_overflow set, address advances.
//  - Pixel index >= H_PIX*V_LINES: write suppressed, err_geom set; no wrap.
//  - href 1->0: if col != H_PIX or phase=1 (odd byte, discarded) -> err_geom;
//    col and phase cleared, row++ (saturates at V_LINES).
//  - Frame end with row != V_LINES -> err_geom; frame_done still pulses.
//  - href & vsync both 1: vsync wins, frame ends, partial line discarded.
//  - Errors sticky until next accepted capture_req or rst.
// STRUCTURE
//  - cam_pkg: state encoding localparams (IDLE/ARM/CAPTURE/DONE), RGB565 byte order.
//  - One sub-module natural: cam_byte_pairer (phase toggle + 16-bit assembly +
//    col count); FSM, address and error logic stay in top.
// TESTING
//  1 rst, capture_req pulse, 4x3 frame (H_PIX=4,V_LINES=3), bytes 0x01..0x18 ->
//    12 pix_we, addr 0..11, pix_data 0x0102..0x1718, one frame_done, no errors.
//  2 capture_req while vsync already low mid-frame -> no writes until next vsync
//    1->0; then full frame captured from addr 0.
//  3 buf_full held high for pixel 5 -> pixel 5 not written, pixel 6 at addr 6,
//    err_overflow=1 through frame_done, cleared by next capture_req.
//  4 line 1 with 7 bytes -> err_geom=1 at href fall, last byte dropped, line 2
//    starts at addr 8.
//  5 rst asserted mid-line 2 -> outputs 0 asynchronously, IDLE, no frame_done;
//    new capture completes normally.
//  6 only 2 lines before vsync rise -> frame_done pulse, err_geom=1; capture_req
//    during CAPTURE ignored (no restart).

Source files
------------

// File: rtl/cam_capture_ctrl_pkg.sv
// ============================================================================
// cam_pkg : shared state encoding and RGB565 byte packing for cam_capture_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

package cam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // OV7670 RGB565 sends the high byte first on the wire
    localparam bit FIRST_BYTE_HIGH = 1'b1;

    function automatic logic [15:0] rgb565_pack(input logic [7:0] first_b,
                                                 input logic [7:0] second_b);
        return FIRST_BYTE_HIGH ? {first_b, second_b} : {second_b, first_b};
    endfunction

endpackage

`default_nettype wire

// File: rtl/cam_capture_ctrl_if.sv
// ============================================================================
// cam_capture_ctrl_if : camera pins in, addressed pixel writes out
// Revision: 1.0
// ============================================================================
`default_nettype none

interface cam_capture_ctrl_if #(
    parameter int ADDR_W = 19
);
    logic              href;
    logic              vsync;
    logic [7:0]        data;
    logic              buf_full;
    logic [15:0]       pix_data;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_we;

    modport master (
        output href, vsync, data, buf_full,
        input  pix_data, pix_addr, pix_we
    );

    modport slave (
        input  href, vsync, data, buf_full,
        output pix_data, pix_addr, pix_we
    );
endinterface

`default_nettype wire

// File: rtl/cam_capture_ctrl_byte_pairer.sv
// ============================================================================
// cam_byte_pairer : byte phase toggle, 16-bit pixel assembly and column count
// Revision: 1.0
// ============================================================================
`default_nettype none

module cam_byte_pairer
    import cam_pkg::*;
#(
    parameter int COL_W = 11
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr,
    input  wire logic             en,
    input  wire logic [7:0]       byte_in,
    output logic                  fire,
    output logic [15:0]           word,
    output logic [COL_W-1:0]      col,
    output logic                  phase
);

    logic [7:0] first_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_byte <= '0;
            phase      <= 1'b0;
            col        <= '0;
        end else if (clr) begin
            phase <= 1'b0;
            col   <= '0;
        end else if (en) begin
            if (!phase) begin
                first_byte <= byte_in;
                phase      <= 1'b1;
            end else begin
                phase <= 1'b0;
                // saturate so an overlong line never aliases back to column 0
                if (col != '1) col <= col + 1'b1;
            end
        end
    end

    assign fire = en & phase;
    assign word = rgb565_pack(first_byte, byte_in);

endmodule

`default_nettype wire

// File: rtl/cam_capture_ctrl.sv
// ============================================================================
// cam_capture_ctrl : one-shot frame capture from an OV7670-style camera port
// Revision: 1.0
// ============================================================================
`default_nettype none

module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int H_PIX   = 640,
    parameter int V_LINES = 480,
    parameter int ADDR_W  = 19
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         capture_req,
    cam_capture_ctrl_if.slave bus,
    output logic              busy,
    output logic              frame_done,
    output logic              err_overflow,
    output logic              err_geom
);

    localparam int COL_W = $clog2(H_PIX + 1) + 1;
    localparam int ROW_W = $clog2(V_LINES + 1);
    localparam logic [COL_W-1:0] COL_FULL  = COL_W'(H_PIX);
    localparam logic [ROW_W-1:0] ROW_FULL  = ROW_W'(V_LINES);
    localparam logic [31:0]      IDX_LIMIT = 32'(H_PIX * V_LINES);

    state_t             state;
    logic               href_r, href_q, vsync_r, armed;
    logic [7:0]         data_r;
    logic [ROW_W-1:0]   row;
    logic               pair_fire, pair_phase;
    logic [15:0]        pair_word;
    logic [COL_W-1:0]   col;
    logic               w_capturing, w_line_end, w_pair_en, w_pair_clr;
    logic [31:0]        w_pix_idx;

    assign w_capturing = (state == ST_CAPTURE);
    // vsync high overrides href: the frame is over, any partial line is dropped
    assign w_pair_en   = w_capturing & href_r & ~vsync_r;
    assign w_line_end  = w_capturing & href_q & ~href_r & ~vsync_r;
    assign w_pair_clr  = ~w_capturing | w_line_end;
    assign w_pix_idx   = 32'(row) * 32'(H_PIX) + 32'(col);

    cam_byte_pairer #(.COL_W(COL_W)) u_pairer (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_pair_clr),
        .en      (w_pair_en),
        .byte_in (data_r),
        .fire    (pair_fire),
        .word    (pair_word),
        .col     (col),
        .phase   (pair_phase)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            href_r       <= 1'b0;
            href_q       <= 1'b0;
            vsync_r      <= 1'b0;
            data_r       <= '0;
            armed        <= 1'b0;
            row          <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            err_overflow <= 1'b0;
            err_geom     <= 1'b0;
            bus.pix_we   <= 1'b0;
            bus.pix_data <= '0;
            bus.pix_addr <= '0;
        end else begin
            href_r     <= bus.href;
            href_q     <= href_r;
            vsync_r    <= bus.vsync;
            data_r     <= bus.data;
            bus.pix_we <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (capture_req) begin
                        state        <= ST_ARM;
                        busy         <= 1'b1;
                        err_overflow <= 1'b0;
                        err_geom     <= 1'b0;
                        row          <= '0;
                        armed        <= 1'b0;
                    end
                end
                ST_ARM: begin
                    // require a blanking interval first so we never join mid-frame
                    if (vsync_r)    armed <= 1'b1;
                    else if (armed) state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (vsync_r) begin
                        state      <= ST_DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        if (row != ROW_FULL) err_geom <= 1'b1;
                    end else begin
                        if (pair_fire) begin
                            if (w_pix_idx >= IDX_LIMIT) begin
                                err_geom <= 1'b1;
                            end else begin
                                bus.pix_addr <= w_pix_idx[ADDR_W-1:0];
                                if (bus.buf_full) begin
                                    err_overflow <= 1'b1;
                                end else begin
                                    bus.pix_we   <= 1'b1;
                                    bus.pix_data <= pair_word;
                                end
                            end
                        end
                        if (w_line_end) begin
                            if (col != COL_FULL || pair_phase) err_geom <= 1'b1;
                            if (row != ROW_FULL) row <= row + 1'b1;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cam_capture_ctrl.sv
// ============================================================================
// tb_cam_capture_ctrl : directed self-checking bench on a 4x3 frame geometry
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cam_capture_ctrl;

    localparam int H = 4;
    localparam int V = 3;
    localparam int AW = 19;

    logic clk = 1'b0;
    logic rst;
    logic capture_req;
    logic busy, frame_done, err_overflow, err_geom;

    int n_chk  = 0;
    int n_fail = 0;

    cam_capture_ctrl_if #(.ADDR_W(AW)) bus ();

    cam_capture_ctrl #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .capture_req  (capture_req),
        .bus          (bus),
        .busy         (busy),
        .frame_done   (frame_done),
        .err_overflow (err_overflow),
        .err_geom     (err_geom)
    );

    always #5 clk = ~clk;

    logic [AW-1:0] wa[$];
    logic [15:0]   wd[$];
    int            done_cnt;
    logic          ovf_at_done, geom_at_done;
    int            gbyte;
    int            full_pix;

    always @(negedge clk) begin
        if (bus.pix_we) begin
            wa.push_back(bus.pix_addr);
            wd.push_back(bus.pix_data);
        end
        if (frame_done) begin
            done_cnt++;
            ovf_at_done  = err_overflow;
            geom_at_done = err_geom;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_req();
        @(negedge clk) capture_req = 1'b1;
        @(negedge clk) capture_req = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        done_cnt     = 0;
        ovf_at_done  = 1'b0;
        geom_at_done = 1'b0;
    endtask

    task automatic begin_frame();
        @(negedge clk) bus.vsync = 1'b1;
        idle(3);
        bus.vsync = 1'b0;
        gbyte = 0;
        idle(3);
    endtask

    task automatic end_frame();
        idle(2);
        bus.vsync = 1'b1;
        idle(5);
    endtask

    // buf_full is raised exactly on the write slot of pixel full_pix (2 clk after its 2nd byte)
    task automatic send_line(input int nbytes);
        for (int j = 0; j < nbytes; j++) begin
            @(negedge clk);
            bus.href     = 1'b1;
            bus.data     = 8'(gbyte + 1);
            bus.buf_full = (full_pix >= 0) && (gbyte - 1 == 2 * full_pix + 1);
            gbyte++;
        end
        @(negedge clk);
        bus.href     = 1'b0;
        bus.buf_full = (full_pix >= 0) && (gbyte - 1 == 2 * full_pix + 1);
        @(negedge clk);
        bus.buf_full = 1'b0;
    endtask

    task automatic chk_frame(input string tag, input int skip);
        int p;
        chk({tag, "_count"}, wa.size(), (skip >= 0) ? 11 : 12);
        p = 0;
        for (int k = 0; k < 12; k++) begin
            if (k != skip && p < wa.size()) begin
                chk({tag, "_addr"}, wa[p], k);
                chk({tag, "_data"}, wd[p], {8'(2 * k + 1), 8'(2 * k + 2)});
                p++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        capture_req = 1'b0;
        bus.href = 1'b0;
        bus.vsync = 1'b1;
        bus.data = 8'h00;
        bus.buf_full = 1'b0;
        full_pix = -1;
        gbyte = 0;
        clear_log();
        idle(3);
        chk("reset_outputs", {busy, frame_done, err_overflow, err_geom, bus.pix_we,
                              bus.pix_addr, bus.pix_data}, 64'h0);
        rst = 1'b0;
        idle(2);

        // 1: clean 4x3 frame
        clear_log();
        pulse_req();
        begin_frame();
        chk("t1_busy_capture", busy, 1'b1);
        for (int l = 0; l < V; l++) send_line(8);
        end_frame();
        chk_frame("t1", -1);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_errs", {ovf_at_done, geom_at_done}, 2'b00);
        chk("t1_busy_after", busy, 1'b0);

        // 2: request lands mid-frame; must wait for the next frame start
        clear_log();
        @(negedge clk) bus.vsync = 1'b0;
        idle(2);
        pulse_req();
        gbyte = 8'h3F;
        send_line(8);
        idle(2);
        chk("t2_no_midframe_writes", wa.size(), 0);
        begin_frame();
        for (int l = 0; l < V; l++) send_line(8);
        end_frame();
        chk_frame("t2", -1);
        chk("t2_done_cnt", done_cnt, 1);

        // 3: buf_full on pixel 5
        clear_log();
        pulse_req();
        full_pix = 5;
        begin_frame();
        for (int l = 0; l < V; l++) send_line(8);
        end_frame();
        full_pix = -1;
        chk_frame("t3", 5);
        chk("t3_ovf_at_done", ovf_at_done, 1'b1);
        chk("t3_ovf_sticky", err_overflow, 1'b1);
        pulse_req();
        idle(1);
        chk("t3_ovf_cleared", err_overflow, 1'b0);

        // 4: line 1 has 7 bytes (DUT already armed by the request above)
        clear_log();
        begin_frame();
        send_line(8);
        idle(1);
        chk("t4_geom_before", err_geom, 1'b0);
        send_line(7);
        idle(1);
        chk("t4_geom_at_fall", err_geom, 1'b1);
        send_line(8);
        end_frame();
        chk("t4_count", wa.size(), 11);
        if (wa.size() == 11) begin
            chk("t4_addr6", wa[6], 6);
            chk("t4_data6", wd[6], 16'h0D0E);
            chk("t4_addr7", wa[7], 8);
            chk("t4_data7", wd[7], 16'h1011);
            chk("t4_addr10", wa[10], 11);
            chk("t4_data10", wd[10], 16'h1617);
        end
        chk("t4_geom_at_done", geom_at_done, 1'b1);
        chk("t4_done_cnt", done_cnt, 1);

        // 5: asynchronous reset in the middle of line 2
        clear_log();
        pulse_req();
        begin_frame();
        send_line(8);
        send_line(8);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            bus.href = 1'b1;
            bus.data = 8'(gbyte + 1);
            gbyte++;
        end
        @(negedge clk);
        chk("t5_busy_before_rst", busy, 1'b1);
        #2 rst = 1'b1;
        #1 chk("t5_async_outputs", {busy, frame_done, err_overflow, err_geom, bus.pix_we,
                                    bus.pix_addr, bus.pix_data}, 64'h0);
        bus.href = 1'b0;
        bus.vsync = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(6);
        chk("t5_no_done", done_cnt, 0);
        chk("t5_idle", busy, 1'b0);
        clear_log();
        pulse_req();
        begin_frame();
        for (int l = 0; l < V; l++) send_line(8);
        end_frame();
        chk_frame("t5b", -1);
        chk("t5b_done_cnt", done_cnt, 1);
        chk("t5b_geom", geom_at_done, 1'b0);

        // 6: short frame (2 lines); request during capture is ignored
        clear_log();
        pulse_req();
        begin_frame();
        send_line(8);
        pulse_req();
        send_line(8);
        end_frame();
        chk("t6_count", wa.size(), 8);
        if (wa.size() == 8) chk("t6_addr7", wa[7], 7);
        chk("t6_done_cnt", done_cnt, 1);
        chk("t6_geom_at_done", geom_at_done, 1'b1);
        idle(3);
        chk("t6_no_restart", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
